// File: rtl/udp_test_sender_pkg.sv
// ---------------------------------------------------------------------------
// udp_test_sender_pkg
// Shared definitions for the periodic UDP test-traffic generator and anything
// that monitors it:
//   - 3-bit state encoding (localparams) and the matching FSM enum
//   - nwords()    : payload length in bytes -> number of 32-bit payload words
//   - pack_word() : payload word format {sequence[15:0], word_index[15:0]}
// ---------------------------------------------------------------------------
package udp_test_sender_pkg;

  // State encoding, kept as plain 3-bit constants so monitors can decode it
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARP_REQ  = 3'd1;
  localparam logic [2:0] S_ARP_WAIT = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_REQ      = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_ARP_REQ  = S_ARP_REQ,
    ST_ARP_WAIT = S_ARP_WAIT,
    ST_GAP      = S_GAP,
    ST_REQ      = S_REQ,
    ST_DATA     = S_DATA,
    ST_FINISH   = S_FINISH
  } state_e;

  // Payload word format: upper half is the packet sequence number (low 16
  // bits of the completed-packet counter), lower half is the word index.
  localparam int unsigned WORD_SEQ_W = 32'd16;
  localparam int unsigned WORD_IDX_W = 32'd16;

  // Number of 32-bit words in a payload of the given byte length
  function automatic logic [15:0] nwords(input logic [15:0] payload_bytes);
    return {2'b00, payload_bytes[15:2]};
  endfunction

  // Build one payload word from sequence number and word index
  function automatic logic [31:0] pack_word(input logic [WORD_SEQ_W-1:0] seq,
                                            input logic [WORD_IDX_W-1:0] idx);
    return {seq, idx};
  endfunction

endpackage

// File: rtl/udp_test_sender_if.sv
// ---------------------------------------------------------------------------
// udp_test_sender_if
// Bundles the ARP-cache resolve handshake and the SEND_* UDP transmit port of
// the GEMAC IP controller.
//   master : the traffic generator (drives requests, length, ports, data)
//   slave  : the IP controller / ARP cache side
// Signals:
//   ARPC_REQUEST     resolve request          ARPC_ENABLE  request accepted
//   ARPC_VALID       peer MAC resolved
//   SEND_REQUEST     packet request           SEND_BUSY    controller owns packet
//   SEND_LENGTH      payload length (bytes)   SEND_SRCPORT/SEND_DSTPORT UDP ports
//   SEND_DATA_VALID  SEND_DATA holds a word   SEND_DATA_READ word consumed
//   SEND_DATA        32-bit payload word
// ---------------------------------------------------------------------------
interface udp_test_sender_if;

  logic        ARPC_REQUEST;
  logic        ARPC_ENABLE;
  logic        ARPC_VALID;
  logic        SEND_REQUEST;
  logic [15:0] SEND_LENGTH;
  logic [15:0] SEND_SRCPORT;
  logic [15:0] SEND_DSTPORT;
  logic        SEND_BUSY;
  logic        SEND_DATA_VALID;
  logic        SEND_DATA_READ;
  logic [31:0] SEND_DATA;

  modport master (
    output ARPC_REQUEST,
    input  ARPC_ENABLE,
    input  ARPC_VALID,
    output SEND_REQUEST,
    output SEND_LENGTH,
    output SEND_SRCPORT,
    output SEND_DSTPORT,
    input  SEND_BUSY,
    output SEND_DATA_VALID,
    input  SEND_DATA_READ,
    output SEND_DATA
  );

  modport slave (
    input  ARPC_REQUEST,
    output ARPC_ENABLE,
    output ARPC_VALID,
    input  SEND_REQUEST,
    input  SEND_LENGTH,
    input  SEND_SRCPORT,
    input  SEND_DSTPORT,
    output SEND_BUSY,
    input  SEND_DATA_VALID,
    output SEND_DATA_READ,
    input  SEND_DATA
  );

endinterface

// File: rtl/udp_test_sender.sv
// ---------------------------------------------------------------------------
// udp_test_sender
// Periodic UDP test-traffic generator. Resolves the peer MAC through the ARP
// cache, then emits fixed-length UDP packets every PERIOD_CYCLES cycles. Each
// payload word is {packet sequence[15:0], word index[15:0]}.
//
// Ports:
//   CLK100MHZ    in   system clock
//   RST_N        in   asynchronous active-low reset
//   ENABLE       in   run generator
//   bus          master side of udp_test_sender_if (ARP + SEND_* handshakes)
//   PKT_COUNT    out  completed packets, wraps
//   ARP_RETRIES  out  ARP re-requests, saturating
//
// All outputs except the constant length/port values are registered.
// ---------------------------------------------------------------------------
module udp_test_sender
  import udp_test_sender_pkg::*;
#(
  parameter logic [15:0] SRC_PORT      = 16'd1234,
  parameter logic [15:0] DST_PORT      = 16'd1234,
  parameter logic [15:0] PAYLOAD_BYTES = 16'd64,         // multiple of 4, 4..1472
  parameter logic [31:0] PERIOD_CYCLES = 32'd100_000_000, // at least 2
  parameter logic [31:0] ARP_TIMEOUT   = 32'd10_000_000   // at least 2
) (
  input  logic               CLK100MHZ,
  input  logic               RST_N,
  input  logic               ENABLE,
  udp_test_sender_if.master  bus,
  output logic [31:0]        PKT_COUNT,
  output logic [15:0]        ARP_RETRIES
);

  localparam logic [15:0] NWORDS     = nwords(PAYLOAD_BYTES);
  localparam logic [15:0] LAST_IDX   = NWORDS - 16'd1;
  localparam logic [31:0] PERIOD_END = PERIOD_CYCLES - 32'd1;
  localparam logic [31:0] ARP_END    = ARP_TIMEOUT - 32'd1;

  state_e      state_r;
  logic [31:0] timer_r;          // shared timer, cleared on every state entry
  logic [15:0] index_r;          // index of the word currently on SEND_DATA
  logic        arpc_request_r;
  logic        send_request_r;
  logic        send_data_valid_r;
  logic [31:0] send_data_r;
  logic [31:0] pkt_count_r;
  logic [15:0] arp_retries_r;

  logic        accept_s;         // controller takes the presented word this cycle

  assign accept_s = send_data_valid_r & bus.SEND_DATA_READ;

  // Constant header fields, not registered
  assign bus.SEND_LENGTH  = PAYLOAD_BYTES;
  assign bus.SEND_SRCPORT = SRC_PORT;
  assign bus.SEND_DSTPORT = DST_PORT;

  assign bus.ARPC_REQUEST    = arpc_request_r;
  assign bus.SEND_REQUEST    = send_request_r;
  assign bus.SEND_DATA_VALID = send_data_valid_r;
  assign bus.SEND_DATA       = send_data_r;
  assign PKT_COUNT           = pkt_count_r;
  assign ARP_RETRIES         = arp_retries_r;

  // Sequencer: FSM, shared timer, word index and all registered outputs
  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_r           <= ST_IDLE;
      timer_r           <= 32'd0;
      index_r           <= 16'd0;
      arpc_request_r    <= 1'b0;
      send_request_r    <= 1'b0;
      send_data_valid_r <= 1'b0;
      send_data_r       <= 32'd0;
      pkt_count_r       <= 32'd0;
      arp_retries_r     <= 16'd0;
    end else begin
      // Free-running count; every transition below overrides it with zero
      timer_r <= timer_r + 32'd1;

      case (state_r)
        ST_IDLE: begin
          arpc_request_r    <= 1'b0;
          send_request_r    <= 1'b0;
          send_data_valid_r <= 1'b0;
          if (ENABLE) begin
            timer_r <= 32'd0;
            if (bus.ARPC_VALID) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_ARP_REQ;
            end
          end
        end

        // The request is raised one cycle after entry; ARPC_ENABLE only
        // counts once the cache has actually seen the request asserted.
        ST_ARP_REQ: begin
          if (arpc_request_r && bus.ARPC_ENABLE) begin
            arpc_request_r <= 1'b0;
            timer_r        <= 32'd0;
            state_r        <= ST_ARP_WAIT;
          end else begin
            arpc_request_r <= 1'b1;
          end
        end

        // A resolution arriving on the timeout cycle still wins
        ST_ARP_WAIT: begin
          if (bus.ARPC_VALID) begin
            timer_r <= 32'd0;
            state_r <= ST_GAP;
          end else if (timer_r == ARP_END) begin
            timer_r <= 32'd0;
            state_r <= ST_ARP_REQ;
            if (arp_retries_r != 16'hFFFF) begin
              arp_retries_r <= arp_retries_r + 16'd1;
            end
          end
        end

        ST_GAP: begin
          if (!ENABLE) begin
            timer_r <= 32'd0;
            state_r <= ST_IDLE;
          end else if (!bus.ARPC_VALID) begin
            timer_r <= 32'd0;
            state_r <= ST_ARP_REQ;
          end else if (timer_r == PERIOD_END) begin
            timer_r        <= 32'd0;
            send_request_r <= 1'b1;
            state_r        <= ST_REQ;
          end
        end

        // Controller grabbing the packet: first word is presented at once
        ST_REQ: begin
          if (bus.SEND_BUSY) begin
            send_request_r    <= 1'b0;
            index_r           <= 16'd0;
            send_data_r       <= pack_word(pkt_count_r[15:0], 16'd0);
            send_data_valid_r <= 1'b1;
            timer_r           <= 32'd0;
            state_r           <= ST_DATA;
          end
        end

        // Accept of the last word beats a simultaneous BUSY drop, so a
        // fully transferred packet is never counted as aborted.
        ST_DATA: begin
          if (accept_s && (index_r == LAST_IDX)) begin
            send_data_valid_r <= 1'b0;
            timer_r           <= 32'd0;
            state_r           <= ST_FINISH;
          end else if (!bus.SEND_BUSY) begin
            send_data_valid_r <= 1'b0;
            timer_r           <= 32'd0;
            state_r           <= ST_GAP;
          end else if (accept_s) begin
            index_r     <= index_r + 16'd1;
            send_data_r <= pack_word(pkt_count_r[15:0], index_r + 16'd1);
          end
        end

        ST_FINISH: begin
          if (!bus.SEND_BUSY) begin
            pkt_count_r <= pkt_count_r + 32'd1;
            timer_r     <= 32'd0;
            if (ENABLE) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end

        default: begin
          arpc_request_r    <= 1'b0;
          send_request_r    <= 1'b0;
          send_data_valid_r <= 1'b0;
          timer_r           <= 32'd0;
          state_r           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
